// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two clients.
// Serializes read/write commands and returns read data with per-client valid.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                  state_q;
  logic                    we_l_q;
  logic                    win_q;
  logic                    last_q;
  logic [1:0]              gnt_q;
  logic [1:0]              rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_din_q;
  logic                    mem_en_q;
  logic                    win_d;

  // On contention the client not served last goes first.
  always_comb begin
    win_d = 1'b0;
    unique case (1'b1)
      (req0 && req1):  win_d = ~last_q;
      (req1 && !req0): win_d = 1'b1;
      default:         win_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_l_q     <= 1'b0;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_en_q   <= 1'b0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            we_l_q     <= win_d ? we1 : we0;
            win_q      <= win_d;
            last_q     <= win_d;
            gnt_q      <= win_d ? 2'b10 : 2'b01;
            mem_en_q   <= win_d ? we1 : we0;
            mem_addr_q <= win_d ? addr1 : addr0;
            mem_din_q  <= win_d ? wdata1 : wdata0;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q  <= 1'b0;
          mem_din_q <= '0;
          if (we_l_q) begin
            mem_addr_q <= '0;
            state_q    <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        RESP: begin
          rdata_q         <= mem_dout;
          rvalid_q[win_q] <= 1'b1;
          mem_addr_q      <= '0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_en   = mem_en_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin controller that shares the single-port 16x32 memory (Address / Data_in / EN / Data_out) between two independent clients. It serializes read and write commands, drives the memory's Address, Data_in and EN pins, and returns read data with a per-requester valid pulse. It sits directly in front of the memory instance; no other logic drives the memory ports.

## Interface
Parameters:
- ADDR_WIDTH, 4, memory address width
- DATA_WIDTH, 32, memory word width

Ports:
- clk  in  1  rising-edge clock, shared with the memory
- rst  in  1  asynchronous, active-low reset; also drives the memory's rst
- req0 / req1  in  1  command request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_WIDTH  command address; stable while req high
- wdata0 / wdata1  in  DATA_WIDTH  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle grant pulse; command accepted
- rvalid0 / rvalid1  out  1  one-cycle read-data-valid pulse
- rdata  out  DATA_WIDTH  read data, shared; qualified by rvalid0/rvalid1
- busy  out  1  high in any state other than IDLE
- mem_addr  out  ADDR_WIDTH  to memory Address
- mem_din  out  DATA_WIDTH  to memory Data_in
- mem_en  out  1  to memory EN (1 = write, 0 = read)
- mem_dout  in  DATA_WIDTH  from memory Data_out

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: mem_en=0, mem_addr=0, mem_din=0. If req0|req1, choose winner, latch its we/addr/wdata and winner id into internal registers, go to ACCESS. Else stay.
- Arbitration: only one req -> that one wins. Both -> the requester not granted last (last_winner register). last_winner updates on every latch. Reset value of last_winner = 1, so requester 0 wins the first contention.
- ACCESS: drive mem_en=we_l, mem_addr=addr_l, mem_din=wdata_l (all from registers). gnt of winner high this cycle only. we_l=1 -> IDLE; we_l=0 -> RESP.
- RESP: mem_en=0, mem_addr=addr_l; mem_dout now holds the word read at end of ACCESS. Register rdata <= mem_dout, assert rvalid of winner next cycle; go to IDLE.
- rdata holds its value until the next read completes; never cleared except by reset.
- Requester rule: keep req/we/addr/wdata stable from assertion through the gnt cycle; deassert req (or present a new command) in the cycle after gnt. A req still high in the IDLE cycle after gnt is a new command.
- Memory valid_out is not used.
- Reset (any time, including mid-ACCESS/RESP): state=IDLE; gnt0/1=0, rvalid0/1=0, rdata=0, busy=0, mem_en=0, mem_addr=0, mem_din=0, last_winner=1; latched command discarded, no late rvalid or gnt after release. Memory contents cleared by the same reset.

## Timing
- Request sampled in IDLE cycle N; gnt in cycle N+1 (ACCESS).
- Write: memory written at end of N+1; back in IDLE at N+2. Write throughput: one per 2 cycles.
- Read: memory captures Data_out at end of N+1; RESP in N+2; rvalid and rdata valid in N+3 (coincides with IDLE). Read latency req->rvalid = 3 cycles; throughput one per 3 cycles.
- gnt, rvalid, rdata, busy are registered or decoded from registered state only; no combinational path from req to any output.
- rvalid0 and rvalid1 never high together; gnt0 and gnt1 never high together; gnt and rvalid of the other requester may coincide.

## Test plan
- Reset: assert rst mid-read (in RESP) -> all outputs 0 next sample, no rvalid after release, memory reads return 0.
- Single write/read: req0 write addr=3 data=0xDEADBEEF, then req0 read addr=3 -> gnt0 one cycle after each req, rvalid0 3 cycles after read req with rdata=0xDEADBEEF.
- Contention: req0 and req1 both high from reset, both reads -> gnt0 first, then gnt1; grants alternate 0,1,0,1 while both stay asserted.
- Mixed back-to-back: req1 write addr=15 data=0x12345678 while req0 reads addr=15 simultaneously after req0 was last granted -> write granted first, req0 read returns 0x12345678 via rvalid0 only.
- Address wrap/boundary: write addr=0 and addr=15 with distinct data from different requesters -> each reads back its own value; rdata holds last value while rvalid low.
- Idle behaviour: no req for 10 cycles -> busy=0, mem_en=0, no gnt/rvalid pulses.
